// File: rtl/mips_host_pkg.sv
// Shared types and constants for the MIPS host-side load/run/readback controller.
package mips_host_pkg;

  typedef enum logic [3:0] {
    IDLE,
    HDR_M,
    HDR_R,
    LOAD_I,
    LOAD_D,
    START,
    WAIT_LO,
    WAIT_HI,
    RD_ISSUE,
    RD_CAP,
    RD_HOLD
  } state_t;

  // Header word positions: instruction count, data count, result count.
  localparam int FLD_N     = 0;
  localparam int FLD_M     = 1;
  localparam int FLD_R     = 2;
  localparam int FLD_COUNT = 3;

  localparam int ADDR_STRIDE = 4;

endpackage

// File: rtl/mips_host_ctrl.sv
// Host initiator: takes a job off a word stream, loads instr/data memory,
// runs the processor with a done timeout, and streams result words back out.
module mips_host_ctrl
  import mips_host_pkg::*;
#(
  parameter int unsigned      WIDTH       = 32,
  parameter logic [WIDTH-1:0] DATA_BASE   = '0,
  parameter logic [WIDTH-1:0] RESULT_BASE = '0,
  parameter int unsigned      TIMEOUT     = 65535
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy,
  output logic             job_done,
  output logic             timeout_err,
  output logic             start,
  output logic             write_instr,
  output logic [WIDTH-1:0] instr_in,
  output logic [WIDTH-1:0] instr_write_adr,
  output logic             write_data,
  output logic             read_data,
  output logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_adr,
  input  logic [WIDTH-1:0] data_out,
  input  logic             done
);

  localparam logic [31:0]      TIMEOUT_CYC = 32'(TIMEOUT);
  localparam logic [WIDTH-1:0] STRIDE      = WIDTH'(ADDR_STRIDE);
  localparam logic [WIDTH-1:0] ONE         = WIDTH'(1);

  state_t                          state_reg, state_next;
  logic [FLD_COUNT-1:0][WIDTH-1:0] hdr_reg, hdr_next;
  logic [WIDTH-1:0]                k_reg, k_next;
  logic [WIDTH-1:0]                j_reg, j_next;
  logic [WIDTH-1:0]                out_data_reg, out_data_next;
  logic [31:0]                     cyc_reg, cyc_next;

  logic             accepting;
  logic             accept;
  logic [WIDTH-1:0] k_inc;
  logic [WIDTH-1:0] j_inc;

  assign k_inc    = k_reg + ONE;
  assign j_inc    = j_reg + ONE;
  // in_ready is gated by reset so it reads 0 while reset is held, even in IDLE.
  assign in_ready = accepting & reset;
  assign accept   = in_ready & in_valid;
  assign busy     = (state_reg != IDLE);
  assign out_data = out_data_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      hdr_reg      <= '0;
      k_reg        <= '0;
      j_reg        <= '0;
      cyc_reg      <= '0;
      out_data_reg <= '0;
    end else begin
      state_reg    <= state_next;
      hdr_reg      <= hdr_next;
      k_reg        <= k_next;
      j_reg        <= j_next;
      cyc_reg      <= cyc_next;
      out_data_reg <= out_data_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    hdr_next        = hdr_reg;
    k_next          = k_reg;
    j_next          = j_reg;
    cyc_next        = cyc_reg;
    out_data_next   = out_data_reg;
    accepting       = 1'b0;
    write_instr     = 1'b0;
    instr_in        = '0;
    instr_write_adr = '0;
    write_data      = 1'b0;
    data_in         = '0;
    data_adr        = '0;
    read_data       = 1'b0;
    start           = 1'b0;
    job_done        = 1'b0;
    timeout_err     = 1'b0;
    out_valid       = 1'b0;
    out_last        = 1'b0;

    unique case (state_reg)
      IDLE: begin
        accepting = 1'b1;
        if (accept) begin
          hdr_next[FLD_N] = in_data;
          state_next      = HDR_M;
        end
      end
      HDR_M: begin
        accepting = 1'b1;
        if (accept) begin
          hdr_next[FLD_M] = in_data;
          state_next      = HDR_R;
        end
      end
      HDR_R: begin
        accepting = 1'b1;
        if (accept) begin
          hdr_next[FLD_R] = in_data;
          k_next          = '0;
          if (hdr_reg[FLD_N] != '0)      state_next = LOAD_I;
          else if (hdr_reg[FLD_M] != '0) state_next = LOAD_D;
          else                           state_next = START;
        end
      end
      LOAD_I: begin
        accepting = 1'b1;
        if (accept) begin
          write_instr     = 1'b1;
          instr_in        = in_data;
          instr_write_adr = STRIDE * k_reg;
          k_next          = k_inc;
          if (k_inc == hdr_reg[FLD_N]) begin
            k_next     = '0;
            state_next = (hdr_reg[FLD_M] != '0) ? LOAD_D : START;
          end
        end
      end
      LOAD_D: begin
        accepting = 1'b1;
        if (accept) begin
          write_data = 1'b1;
          data_in    = in_data;
          data_adr   = DATA_BASE + STRIDE * k_reg;
          k_next     = k_inc;
          if (k_inc == hdr_reg[FLD_M]) begin
            k_next     = '0;
            state_next = START;
          end
        end
      end
      START: begin
        start      = 1'b1;
        cyc_next   = '0;
        j_next     = '0;
        state_next = WAIT_LO;
      end
      WAIT_LO: begin
        // A done level left over from the previous run must drop before it counts.
        cyc_next = cyc_reg + 32'd1;
        if (cyc_reg == TIMEOUT_CYC) begin
          timeout_err = 1'b1;
          state_next  = IDLE;
        end else if (!done) begin
          state_next = WAIT_HI;
        end
      end
      WAIT_HI: begin
        cyc_next = cyc_reg + 32'd1;
        if (done) begin
          if (hdr_reg[FLD_R] != '0) begin
            state_next = RD_ISSUE;
          end else begin
            job_done   = 1'b1;
            state_next = IDLE;
          end
        end else if (cyc_reg == TIMEOUT_CYC) begin
          timeout_err = 1'b1;
          state_next  = IDLE;
        end
      end
      RD_ISSUE: begin
        read_data  = 1'b1;
        data_adr   = RESULT_BASE + STRIDE * j_reg;
        state_next = RD_CAP;
      end
      RD_CAP: begin
        out_data_next = data_out;
        state_next    = RD_HOLD;
      end
      RD_HOLD: begin
        out_valid = 1'b1;
        out_last  = (j_inc == hdr_reg[FLD_R]);
        if (out_ready) begin
          j_next = j_inc;
          if (j_inc == hdr_reg[FLD_R]) begin
            job_done   = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = RD_ISSUE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mips_host_ctrl.sv
// Self-checking bench for mips_host_ctrl: job table plus processor/memory model
// and scoreboard queues for memory writes, result reads and output words.
module tb_mips_host_ctrl;

  localparam logic [31:0] DB = 32'h0000_0100;
  localparam logic [31:0] RB = 32'h0000_0200;
  localparam int          TO = 100;

  logic        clk, reset;
  logic        in_valid, in_ready;
  logic [31:0] in_data;
  logic        out_valid, out_ready, out_last;
  logic [31:0] out_data;
  logic        busy, job_done, timeout_err, start;
  logic        write_instr, write_data, read_data;
  logic [31:0] instr_in, instr_write_adr, data_in, data_adr, data_out;
  logic        done;

  mips_host_ctrl #(
    .WIDTH(32), .DATA_BASE(DB), .RESULT_BASE(RB), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .job_done(job_done), .timeout_err(timeout_err), .start(start),
    .write_instr(write_instr), .instr_in(instr_in), .instr_write_adr(instr_write_adr),
    .write_data(write_data), .read_data(read_data), .data_in(data_in), .data_adr(data_adr),
    .data_out(data_out), .done(done)
  );

  typedef struct packed {
    logic [1:0]  kind;   // 2'b10 instr write, 2'b01 data write
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct packed {
    logic [31:0] d;
    logic        last;
  } out_t;

  typedef struct {
    int              n, m, r, lo, hi, stall;
    bit              never, gap, exp_to;
    logic [3:0][31:0] iw, dw, res;
  } job_t;

  wr_t         exp_wr[$];
  logic [31:0] exp_rd[$];
  out_t        exp_out[$];
  logic [31:0] res_mem [logic [31:0]];
  job_t        jobs[6];

  int n_vec = 0, n_err = 0;
  int cyc = 0;
  int start_cnt = 0, done_cnt = 0, to_cnt = 0, start_cyc = 0, to_cyc = 0, out_total = 0;
  int cur_lo = 1, cur_hi = 1, cur_stall = -1;
  bit cur_never = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Processor stand-in: done is high (stale) until after start, falls, then rises.
  initial begin
    done = 1'b1;
    forever begin
      @(negedge clk);
      if (start) begin
        repeat (cur_lo) @(posedge clk);
        #1 done = 1'b0;
        if (!cur_never) begin
          repeat (cur_hi) @(posedge clk);
          #1 done = 1'b1;
        end else begin
          for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (timeout_err) break;
          end
          @(posedge clk);
          #1 done = 1'b1;
        end
      end
    end
  end

  // Data memory read port: word appears one cycle after read_data.
  initial begin
    logic        rd;
    logic [31:0] a;
    data_out = '0;
    forever begin
      @(negedge clk);
      rd = read_data;
      a  = data_adr;
      @(posedge clk);
      #1;
      if (rd) data_out = res_mem.exists(a) ? res_mem[a] : 32'hBAD0_BAD0;
    end
  end

  // Output consumer: stalls the selected word for 5 cycles.
  initial begin
    int st;
    st = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (out_total != cur_stall) st = 0;
      if (out_valid && out_total == cur_stall && st < 5) begin
        out_ready = 1'b0;
        st++;
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  // Monitor / scoreboard.
  initial forever begin
    wr_t  w;
    out_t o;
    logic [31:0] a;
    @(negedge clk);
    if (reset) begin
      if (write_instr || write_data) begin
        if (exp_wr.size() == 0) chk("unexpected_write", 1, 0);
        else begin
          w = exp_wr.pop_front();
          chk("wr_kind", 32'({write_instr, write_data}), 32'(w.kind));
          chk("wr_addr", write_instr ? instr_write_adr : data_adr, w.addr);
          chk("wr_data", write_instr ? instr_in : data_in, w.data);
        end
      end
      if (read_data) begin
        if (exp_rd.size() == 0) chk("unexpected_read", 1, 0);
        else begin
          a = exp_rd.pop_front();
          chk("rd_addr", data_adr, a);
        end
      end
      if (start) begin
        start_cnt++;
        start_cyc = cyc;
        chk("in_ready_in_start", 32'(in_ready), 0);
      end
      if (job_done) done_cnt++;
      if (timeout_err) begin
        to_cnt++;
        to_cyc = cyc;
      end
      if (out_valid) begin
        chk("in_ready_in_rd", 32'(in_ready), 0);
        if (exp_out.size() == 0) chk("unexpected_out", 1, 0);
        else begin
          chk("out_data", out_data, exp_out[0].d);
          if (out_ready) begin
            o = exp_out.pop_front();
            chk("out_last", 32'(out_last), 32'(o.last));
            out_total++;
          end
        end
      end
    end
  end

  task automatic send_word(input logic [31:0] w, input bit gap);
    int  t;
    bit  acc;
    t = 0;
    if (gap) begin
      in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = w;
    forever begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      t++;
      if (t > 200) begin
        chk("in_accept_bound", 0, 1);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic run_job(input int ji);
    job_t jb;
    int   s0, d0, t0, t;
    jb = jobs[ji];
    s0 = start_cnt; d0 = done_cnt; t0 = to_cnt; t = 0;
    for (int i = 0; i < jb.n; i++) exp_wr.push_back({2'b10, 32'(4 * i), jb.iw[i]});
    for (int i = 0; i < jb.m; i++) exp_wr.push_back({2'b01, DB + 32'(4 * i), jb.dw[i]});
    for (int i = 0; i < jb.r; i++) begin
      res_mem[RB + 32'(4 * i)] = jb.res[i];
      if (!jb.exp_to) begin
        exp_rd.push_back(RB + 32'(4 * i));
        exp_out.push_back({jb.res[i], i == jb.r - 1});
      end
    end
    cur_lo    = jb.lo;
    cur_hi    = jb.hi;
    cur_never = jb.never;
    cur_stall = (jb.stall >= 0) ? out_total + jb.stall : -1;

    send_word(32'(jb.n), 1'b0);
    send_word(32'(jb.m), 1'b0);
    send_word(32'(jb.r), 1'b0);
    for (int i = 0; i < jb.n; i++) send_word(jb.iw[i], jb.gap);
    for (int i = 0; i < jb.m; i++) send_word(jb.dw[i], jb.gap);
    // Junk held on the input while the controller is not accepting.
    in_valid = 1'b1;
    in_data  = 32'hDEAD_BEEF;
    while (done_cnt == d0 && to_cnt == t0) begin
      @(negedge clk);
      #1;
      t++;
      if (t > 2000) begin
        chk("job_end_bound", 0, 1);
        break;
      end
    end
    in_valid = 1'b0;
    chk("start_pulses", 32'(start_cnt - s0), 1);
    chk("job_done_pulses", 32'(done_cnt - d0), 32'(!jb.exp_to));
    chk("timeout_pulses", 32'(to_cnt - t0), 32'(jb.exp_to));
    if (jb.exp_to) begin
      chk("timeout_latency", 32'(to_cyc - start_cyc), 32'(TO + 1));
      @(negedge clk);
      #1;
      chk("busy_after_timeout", 32'(busy), 0);
    end
    chk("writes_left", 32'(exp_wr.size()), 0);
    chk("reads_left", 32'(exp_rd.size()), 0);
    chk("outs_left", 32'(exp_out.size()), 0);
    $display("job %0d: n=%0d m=%0d r=%0d timeout=%0d ended at cycle %0d", ji, jb.n, jb.m, jb.r, jb.exp_to, cyc);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 6; i++) begin
      jobs[i] = '{default: 0};
      jobs[i].stall = -1;
    end
    jobs[0].n = 2; jobs[0].m = 1; jobs[0].r = 1; jobs[0].lo = 3; jobs[0].hi = 20;
    jobs[0].iw[0] = 32'h2008_0005; jobs[0].iw[1] = 32'hAC08_0000;
    jobs[0].dw[0] = 32'h0000_000A; jobs[0].res[0] = 32'h0000_0005;
    jobs[1].lo = 2; jobs[1].hi = 4;
    jobs[2].n = 1; jobs[2].r = 2; jobs[2].lo = 3; jobs[2].never = 1; jobs[2].exp_to = 1;
    jobs[2].iw[0] = 32'h0000_0001;
    jobs[3].m = 1; jobs[3].r = 3; jobs[3].lo = 1; jobs[3].hi = 5; jobs[3].stall = 1;
    jobs[3].dw[0] = 32'h0000_0077;
    jobs[3].res[0] = 32'h1111_1111; jobs[3].res[1] = 32'h2222_2222; jobs[3].res[2] = 32'h3333_3333;
    jobs[4].n = 4; jobs[4].r = 1; jobs[4].lo = 2; jobs[4].hi = 3; jobs[4].gap = 1;
    jobs[4].iw[0] = 32'h0123_4567; jobs[4].iw[1] = 32'h89AB_CDEF;
    jobs[4].iw[2] = 32'h5555_AAAA; jobs[4].iw[3] = 32'hFFFF_0000; jobs[4].res[0] = 32'h0000_CAFE;
    jobs[5].n = 1; jobs[5].lo = 2; jobs[5].hi = 2; jobs[5].iw[0] = 32'h0000_1234;

    reset = 1'b0; in_valid = 1'b0; in_data = '0;
    #1;
    chk("rst_strobes", 32'({in_ready, out_valid, out_last, busy, job_done, timeout_err,
                            start, write_instr, write_data, read_data}), 0);
    chk("rst_buses", instr_in | instr_write_adr | data_in | data_adr | out_data, 0);
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("in_ready_after_rst", 32'(in_ready), 1);

    for (int i = 0; i < 5; i++) run_job(i);

    // Reset in the middle of LOAD_D: drop everything, then start a fresh job.
    cur_never = 1'b0; cur_lo = 1; cur_hi = 1; cur_stall = -1;
    exp_wr.push_back({2'b10, 32'h0, 32'h0000_00AA});
    exp_wr.push_back({2'b01, DB, 32'h0000_00BB});
    send_word(32'd1, 1'b0);
    send_word(32'd2, 1'b0);
    send_word(32'd0, 1'b0);
    send_word(32'h0000_00AA, 1'b0);
    send_word(32'h0000_00BB, 1'b0);
    in_valid = 1'b1;
    in_data  = 32'h0000_00CC;
    #1 reset = 1'b0;
    #1;
    chk("abort_strobes", 32'({in_ready, out_valid, out_last, busy, job_done, timeout_err,
                              start, write_instr, write_data, read_data}), 0);
    chk("abort_buses", instr_in | instr_write_adr | data_in | data_adr, 0);
    in_valid = 1'b0;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("in_ready_after_abort", 32'(in_ready), 1);
    chk("abort_writes_seen", 32'(exp_wr.size()), 0);
    run_job(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
